trumpet_noise_gate: RTL and testbench

//  Downward noise gate sitting directly upstream of the resonator stage: mutes mic

---
 rtl/trumpet_noise_gate_pkg.sv | 25 ++
 rtl/trumpet_noise_gate_if.sv | 14 +
 rtl/trumpet_noise_gate_env_follower.sv | 48 ++++
 rtl/trumpet_noise_gate.sv | 147 ++++++++++++++
 tb/tb_trumpet_noise_gate.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/trumpet_noise_gate_pkg.sv
// rtl/trumpet_noise_gate_pkg.sv - shared types, gain constants and magnitude helper for the noise gate
package trumpet_noise_gate_pkg;

  typedef enum logic [2:0] {
    ST_CLOSED  = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_OPEN    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RELEASE = 3'd4
  } gate_state_t;

  localparam int GAIN_W  = 16;
  localparam int GAIN_IW = 17;
  localparam logic [GAIN_W-1:0] UNITY_GAIN = 16'd32768;

  // |x| with -32768 folded to 32767 so the envelope never exceeds 15 bits
  function automatic logic [15:0] abs_sat16(input logic signed [15:0] x);
    logic [15:0] r;
    if (x == 16'sh8000) r = 16'd32767;
    else if (x < 0)     r = $unsigned(-x);
    else                r = $unsigned(x);
    return r;
  endfunction

endpackage

// File: rtl/trumpet_noise_gate_if.sv
// rtl/trumpet_noise_gate_if.sv - sample stream and status bundle between source and noise gate
interface trumpet_noise_gate_if;
  logic               enable;
  logic               in_valid;
  logic signed [15:0] in_sample;
  logic               out_valid;
  logic signed [15:0] out_sample;
  logic               gate_open;

  modport master (output enable, in_valid, in_sample,
                  input  out_valid, out_sample, gate_open);
  modport slave  (input  enable, in_valid, in_sample,
                  output out_valid, out_sample, gate_open);
endinterface

// File: rtl/trumpet_noise_gate_env_follower.sv
// rtl/trumpet_noise_gate_env_follower.sv - one-pole envelope follower (gate_env_follower)
// Optional sidechain first-difference HPF: NOISE_GATE_SIDECHAIN_HPF_EN
module gate_env_follower
  import trumpet_noise_gate_pkg::*;
#(
  parameter int ENV_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  input  logic signed [15:0] i_sample,
  output logic [15:0]        o_env_next
);

  logic [15:0]        r_env;
  logic signed [15:0] w_det;
  logic [15:0]        w_mag;
  logic signed [16:0] w_diff;
  logic signed [16:0] w_step;
  logic signed [16:0] w_sum;

`ifdef NOISE_GATE_SIDECHAIN_HPF_EN
  logic signed [15:0] r_prev;
  logic signed [16:0] w_fd;

  assign w_fd  = {i_sample[15], i_sample} - {r_prev[15], r_prev};
  assign w_det = w_fd[16:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_prev <= '0;
    else if (i_valid) r_prev <= i_sample;
  end
`else
  assign w_det = i_sample;
`endif

  assign w_mag      = abs_sat16(w_det);
  assign w_diff     = $signed({1'b0, w_mag}) - $signed({1'b0, r_env});
  assign w_step     = w_diff >>> ENV_SHIFT;
  assign w_sum      = $signed({1'b0, r_env}) + w_step;
  assign o_env_next = w_sum[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       r_env <= '0;
    else if (i_valid) r_env <= o_env_next;
  end

endmodule

// File: rtl/trumpet_noise_gate.sv
// rtl/trumpet_noise_gate.sv - downward noise gate: hysteresis FSM, ramped Q1.15 gain, 2-stage output
// Optional sidechain HPF: NOISE_GATE_SIDECHAIN_HPF_EN (inside gate_env_follower)
module trumpet_noise_gate
  import trumpet_noise_gate_pkg::*;
#(
  parameter int ENV_SHIFT    = 4,
  parameter int OPEN_THRESH  = 1024,
  parameter int CLOSE_THRESH = 512,
  parameter int HOLD_SAMPLES = 480,
  parameter int ATTACK_STEP  = 1024,
  parameter int RELEASE_STEP = 64,
  parameter int FLOOR_GAIN   = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  trumpet_noise_gate_if.slave bus
);

  localparam logic [15:0]        OPEN_T  = 16'(OPEN_THRESH);
  localparam logic [15:0]        CLOSE_T = 16'(CLOSE_THRESH);
  localparam logic [15:0]        HOLD_M1 = 16'(HOLD_SAMPLES - 1);
  localparam logic [GAIN_IW-1:0] ATK_I   = 17'(ATTACK_STEP);
  localparam logic [GAIN_IW-1:0] REL_I   = 17'(RELEASE_STEP);
  localparam logic [GAIN_IW-1:0] FLOOR_I = 17'(FLOOR_GAIN);
  localparam logic [GAIN_W-1:0]  FLOOR_G = 16'(FLOOR_GAIN);

  gate_state_t        r_state, w_state_nx;
  logic [GAIN_W-1:0]  r_gain, w_gain_nx;
  logic [15:0]        r_hold, w_hold_nx;
  logic signed [15:0] r_sample;
  logic               r_v1;
  logic signed [15:0] r_out;
  logic               r_ov;

  logic [15:0]        w_env_next;
  logic               w_open_hit, w_close_hit;
  logic [GAIN_IW-1:0] w_atk_sum, w_rel_diff;
  logic [GAIN_W-1:0]  w_atk_gain, w_rel_gain;

  gate_env_follower #(.ENV_SHIFT(ENV_SHIFT)) u_env (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_valid    (bus.in_valid),
    .i_sample   (bus.in_sample),
    .o_env_next (w_env_next)
  );

  assign w_open_hit  = (w_env_next >= OPEN_T);
  assign w_close_hit = (w_env_next <  CLOSE_T);

  assign w_atk_sum  = {1'b0, r_gain} + ATK_I;
  assign w_atk_gain = (w_atk_sum > {1'b0, UNITY_GAIN}) ? UNITY_GAIN : w_atk_sum[GAIN_W-1:0];
  // Borrow in bit 16 means the step would undershoot zero
  assign w_rel_diff = {1'b0, r_gain} - REL_I;
  assign w_rel_gain = (w_rel_diff[GAIN_IW-1] || (w_rel_diff < FLOOR_I)) ? FLOOR_G
                                                                         : w_rel_diff[GAIN_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLOSED;
      r_gain  <= FLOOR_G;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gain  <= w_gain_nx;
      r_hold  <= w_hold_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_gain_nx  = r_gain;
    w_hold_nx  = r_hold;
    if (bus.in_valid) begin
      if (!bus.enable) begin
        w_state_nx = ST_OPEN;
        w_gain_nx  = UNITY_GAIN;
        w_hold_nx  = '0;
      end else begin
        case (r_state)
          ST_CLOSED: begin
            w_gain_nx = FLOOR_G;
            if (w_open_hit) w_state_nx = ST_ATTACK;
          end
          ST_ATTACK: begin
            w_gain_nx = w_atk_gain;
            if (w_close_hit)                    w_state_nx = ST_RELEASE;
            else if (w_atk_gain == UNITY_GAIN)  w_state_nx = ST_OPEN;
          end
          ST_OPEN: begin
            w_gain_nx = UNITY_GAIN;
            if (w_close_hit) begin
              w_state_nx = ST_HOLD;
              w_hold_nx  = HOLD_M1;
            end
          end
          ST_HOLD: begin
            if (w_open_hit)         w_state_nx = ST_OPEN;
            else if (r_hold == '0)  w_state_nx = ST_RELEASE;
            else                    w_hold_nx  = r_hold - 16'd1;
          end
          ST_RELEASE: begin
            w_gain_nx = w_rel_gain;
            if (w_open_hit)                  w_state_nx = ST_ATTACK;
            else if (w_rel_gain == FLOOR_G)  w_state_nx = ST_CLOSED;
          end
          default: begin
            w_state_nx = ST_CLOSED;
            w_gain_nx  = FLOOR_G;
          end
        endcase
      end
    end
  end

  always_comb begin
    bus.gate_open = (r_state == ST_ATTACK) || (r_state == ST_OPEN) || (r_state == ST_HOLD);
  end

  logic signed [32:0] w_a, w_b, w_prod, w_shift;
  logic signed [15:0] w_clamped;

  assign w_a     = {{17{r_sample[15]}}, r_sample};
  assign w_b     = {17'b0, r_gain};
  assign w_prod  = w_a * w_b;
  assign w_shift = w_prod >>> 15;
  assign w_clamped = (w_shift >  33'sd32767) ? 16'sh7fff :
                     (w_shift < -33'sd32768) ? 16'sh8000 : w_shift[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1     <= 1'b0;
      r_sample <= '0;
      r_ov     <= 1'b0;
      r_out    <= '0;
    end else begin
      r_v1 <= bus.in_valid;
      if (bus.in_valid) r_sample <= bus.in_sample;
      r_ov <= r_v1;
      if (r_v1) r_out <= w_clamped;
    end
  end

  assign bus.out_valid  = r_ov;
  assign bus.out_sample = r_out;

endmodule

// File: tb/tb_trumpet_noise_gate.sv
// tb/tb_trumpet_noise_gate.sv - randomized bench for trumpet_noise_gate against a sample-level model
module tb_trumpet_noise_gate;

  localparam int ENV_SHIFT = 4;
  localparam int OPEN_T    = 1024;
  localparam int CLOSE_T   = 512;
  localparam int HOLD_N    = 480;
  localparam int ATK       = 1024;
  localparam int REL       = 64;
  localparam int FLOOR     = 0;
  localparam int UNITY     = 32768;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trumpet_noise_gate_if bus();

  trumpet_noise_gate #(
    .ENV_SHIFT(ENV_SHIFT), .OPEN_THRESH(OPEN_T), .CLOSE_THRESH(CLOSE_T),
    .HOLD_SAMPLES(HOLD_N), .ATTACK_STEP(ATK), .RELEASE_STEP(REL), .FLOOR_GAIN(FLOOR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef enum {M_CLOSED, M_ATTACK, M_OPEN, M_HOLD, M_RELEASE} mode_t;
  typedef struct { bit v; int y; } exp_t;

  mode_t m_mode;
  int    m_env, m_gain, m_hold_left, m_prev;
  bit    exp_open;
  exp_t  exp_q[$];

  function automatic int floor_shift(input int a, input int sh);
    int d;
    d = 1 << sh;
    return (a >= 0) ? a / d : -((-a + d - 1) / d);
  endfunction

  function automatic bit model_open();
    return (m_mode == M_ATTACK) || (m_mode == M_OPEN) || (m_mode == M_HOLD);
  endfunction

  task automatic model_reset();
    m_mode = M_CLOSED; m_env = 0; m_gain = FLOOR; m_hold_left = 0; m_prev = 0;
  endtask

  task automatic model_step(input int x, input bit en, output int y);
    int det, mag, p;
`ifdef NOISE_GATE_SIDECHAIN_HPF_EN
    det = floor_shift(x - m_prev, 1);
    m_prev = x;
`else
    det = x;
`endif
    mag = (det < 0) ? -det : det;
    if (mag > 32767) mag = 32767;
    m_env = m_env + floor_shift(mag - m_env, ENV_SHIFT);
    if (!en) begin
      m_mode = M_OPEN; m_gain = UNITY; m_hold_left = 0;
    end else begin
      case (m_mode)
        M_CLOSED: begin
          m_gain = FLOOR;
          if (m_env >= OPEN_T) m_mode = M_ATTACK;
        end
        M_ATTACK: begin
          m_gain = (m_gain + ATK > UNITY) ? UNITY : m_gain + ATK;
          if (m_env < CLOSE_T) m_mode = M_RELEASE;
          else if (m_gain == UNITY) m_mode = M_OPEN;
        end
        M_OPEN: begin
          m_gain = UNITY;
          if (m_env < CLOSE_T) begin m_mode = M_HOLD; m_hold_left = HOLD_N; end
        end
        M_HOLD: begin
          m_hold_left--;
          if (m_env >= OPEN_T) m_mode = M_OPEN;
          else if (m_hold_left == 0) m_mode = M_RELEASE;
        end
        default: begin
          m_gain = (m_gain - REL < FLOOR) ? FLOOR : m_gain - REL;
          if (m_env >= OPEN_T) m_mode = M_ATTACK;
          else if (m_gain == FLOOR) m_mode = M_CLOSED;
        end
      endcase
    end
    p = floor_shift(x * m_gain, 15);
    y = (p > 32767) ? 32767 : (p < -32768) ? -32768 : p;
  endtask

  task automatic drive(input bit v, input int x, input bit en);
    exp_t e;
    int   y;
    @(negedge clk);
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check("out_valid", bus.out_valid, e.v);
      if (e.v) check("out_sample", bus.out_sample, e.y);
    end
    check("gate_open", bus.gate_open, exp_open);
    bus.in_valid  = v;
    bus.in_sample = 16'(x);
    bus.enable    = en;
    y = 0;
    if (v) model_step(x, en, y);
    exp_q.push_back('{v, y});
    exp_open = model_open();
  endtask

  // mode 0: constant amp, mode 1: uniform random in [-amp, amp]
  task automatic run(input int n, input int amp, input int mode, input int vprob, input bit en);
    int x;
    bit v;
    for (int i = 0; i < n; i++) begin
      v = ($urandom_range(99, 0) < vprob);
      if (mode == 0) x = amp;
      else x = int'($urandom_range(2 * amp, 0)) - amp;
      if (x > 32767) x = 32767;
      drive(v, x, en);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("rst_out_sample", bus.out_sample, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_gate_open", bus.gate_open, 0);
    model_reset();
    exp_q.delete();
    exp_q.push_back('{1'b0, 0});
    exp_q.push_back('{1'b0, 0});
    exp_open = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int amps[5] = '{50, 400, 2000, 12000, 32767};
    bus.enable    = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    model_reset();
    do_reset();

    run(20, 0, 0, 100, 1'b1);
    run(60, 8000, 0, 100, 1'b1);
    check("unity_passthrough", bus.out_sample,
`ifdef NOISE_GATE_SIDECHAIN_HPF_EN
          0
`else
          8000
`endif
          );
    run(1100, 100, 0, 100, 1'b1);
    run(40, 8000, 0, 100, 1'b1);
    run(200, 100, 0, 100, 1'b1);
    run(5, 20000, 0, 100, 1'b1);
    run(1100, 100, 0, 100, 1'b1);

    run(40, 8000, 0, 100, 1'b1);
    run(600, -32768, 0, 100, 1'b1);

    run(800, 100, 0, 100, 1'b1);
    run(60, 3000, 1, 100, 1'b0);
    run(100, 100, 0, 100, 1'b1);

    for (int k = 0; k < 20; k++) begin
      run($urandom_range(200, 20), amps[$urandom_range(4, 0)], $urandom_range(1, 0),
          $urandom_range(100, 30), ($urandom_range(9, 0) != 0));
    end

    run(10, 8000, 0, 100, 1'b1);
    do_reset();
    run(20, 0, 0, 100, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
